// File: rtl/cdc_req_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cdc_req_ctrl_if
// Brief    : Local valid/ready bundle plus remote req/ack/data for cdc_req_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface cdc_req_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] xdata_o;
  logic             xreq_o;
  logic             xack_async_i;
  logic             done_o;
  logic             timeout_o;
  logic             err_o;
  logic             clr_err_i;

  modport master (
    output valid_i, data_i, xack_async_i, clr_err_i,
    input  ready_o, xdata_o, xreq_o, done_o, timeout_o, err_o
  );

  modport slave (
    input  valid_i, data_i, xack_async_i, clr_err_i,
    output ready_o, xdata_o, xreq_o, done_o, timeout_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/cdc_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cdc_req_ctrl
// Brief    : Source-side four-phase req/ack controller moving a WIDTH-bit word
//            into a foreign clock domain. Phase timeout / sticky error logic is
//            built only when CDC_REQ_CTRL_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_req_ctrl #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  cdc_req_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_xreq;
  logic             w_xreq_nxt;
  logic [WIDTH-1:0] r_xdata;
  logic [WIDTH-1:0] w_xdata_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_ready;
  logic             w_timeout;

  (* ASYNC_REG = "TRUE" *) logic r_ack_s1;
  (* ASYNC_REG = "TRUE" *) logic r_ack_s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
    end else begin
      r_ack_s1 <= bus.xack_async_i;
      r_ack_s2 <= r_ack_s1;
    end
  end

  // A stale ack left over from an interrupted transfer must drain first.
  assign w_ready = (r_state == S_IDLE) && !r_ack_s2;

`ifdef CDC_REQ_CTRL_TIMEOUT_EN
  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_timeout;
  logic               r_err;

  // Fires on the cycle the count would reach TIMEOUT_CYCLES, so each phase
  // gets exactly TIMEOUT_CYCLES cycles before the registered pulse.
  assign w_timeout = (r_cnt == c_CNT_LAST) &&
                     (((r_state == S_REQ) && !r_ack_s2) ||
                      ((r_state == S_REL) &&  r_ack_s2));

  always_comb begin
    w_cnt_nxt = r_cnt + 1'b1;
    if ((r_state == S_IDLE) || w_timeout || ((r_state == S_REQ) && r_ack_s2)) begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout;
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (bus.clr_err_i) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.timeout_o = r_timeout;
  assign bus.err_o     = r_err;
`else
  logic w_unused_clr;

  assign w_unused_clr  = bus.clr_err_i;
  assign w_timeout     = 1'b0;
  assign bus.timeout_o = 1'b0;
  assign bus.err_o     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_xreq_nxt  = r_xreq;
    w_xdata_nxt = r_xdata;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.valid_i && w_ready) begin
          w_xdata_nxt = bus.data_i;
          w_xreq_nxt  = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (r_ack_s2 || w_timeout) begin
          w_xreq_nxt  = 1'b0;
          w_state_nxt = S_REL;
        end
      end
      S_REL: begin
        if (!r_ack_s2) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_xreq_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_xreq  <= 1'b0;
      r_xdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_xreq  <= w_xreq_nxt;
      r_xdata <= w_xdata_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.xreq_o  = r_xreq;
  assign bus.xdata_o = r_xdata;
  assign bus.done_o  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cdc_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_req_ctrl
// Brief    : Directed self-checking bench for cdc_req_ctrl (TIMEOUT_CYCLES=16)
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_req_ctrl;

  typedef struct {
    logic [31:0] data;
    int          dly;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  // Remote model: ack follows xreq through ack_dly cycles, or is forced.
  logic       ack_manual = 1'b1;
  logic       ack_force  = 1'b0;
  int         ack_dly    = 3;
  logic [7:0] hist       = '0;
  logic [8:0] w_hist;

  cdc_req_ctrl_if #(.WIDTH(32)) bus ();

  cdc_req_ctrl #(
    .WIDTH          (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) hist <= {hist[6:0], bus.xreq_o};
  assign w_hist           = {hist, bus.xreq_o};
  assign bus.xack_async_i = ack_manual ? ack_force : w_hist[ack_dly];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready_o && n < 50) begin
      tick();
      n++;
    end
    check("wait_ready", bus.ready_o, 1);
  endtask

  // Accept one word; returns with the sample taken just after the accept edge.
  task automatic accept(input logic [31:0] d);
    wait_ready();
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    tick();
    bus.valid_i = 1'b0;
    bus.data_i  = ~d;
  endtask

  task automatic do_xfer(input logic [31:0] d, input int dly, input int lat);
    bit stable = 1'b1;
    int ndone  = 0;
    int at     = -1;
    ack_manual = 1'b0;
    ack_dly    = dly;
    accept(d);
    check("xfer_xreq_rise", bus.xreq_o, 1);
    check("xfer_ready_busy", bus.ready_o, 0);
    for (int k = 1; k <= lat + 4; k++) begin
      tick();
      if (bus.done_o) begin
        ndone++;
        if (at < 0) begin
          at = k;
          check("xfer_ready_at_done", bus.ready_o, 1);
        end
      end
      if (bus.xdata_o !== d) stable = 1'b0;
    end
    check("xfer_xdata_stable", stable, 1);
    check("xfer_done_count", ndone, 1);
    check("xfer_done_latency", at, lat);
  endtask

  task automatic back_to_back();
    logic [31:0] xs[$];
    int   idx = 0;
    int   ndone = 0;
    int   extra = 0;
    logic prev_xreq = 1'b0;
    logic acc;
    ack_manual  = 1'b0;
    ack_dly     = 3;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'd1;
    for (int c = 0; c < 200 && ndone < 3; c++) begin
      acc = bus.ready_o && bus.valid_i;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) bus.data_i = 32'(idx + 1);
        else         bus.valid_i = 1'b0;
      end
      if (bus.xreq_o && !prev_xreq) xs.push_back(bus.xdata_o);
      if (bus.done_o) ndone++;
      prev_xreq = bus.xreq_o;
    end
    bus.valid_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done_o) extra++;
    end
    check("b2b_done_count", ndone, 3);
    check("b2b_extra_done", extra, 0);
    check("b2b_xfer_count", xs.size(), 3);
    for (int i = 0; i < xs.size() && i < 3; i++) check("b2b_xdata_seq", xs[i], 64'(i + 1));
  endtask

  task automatic reset_mid_req();
    bit rdy_bad  = 1'b0;
    bit done_bad = 1'b0;
    ack_manual = 1'b1;
    ack_force  = 1'b0;
    accept(32'hCAFEF00D);
    ack_force = 1'b1;
    tick();
    check("rst_pre_xreq", bus.xreq_o, 1);
    rst = 1'b1;
    tick();
    check("rst_xreq_low", bus.xreq_o, 0);
    check("rst_xdata_zero", bus.xdata_o, 0);
    rst = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      tick();
      if (bus.done_o) done_bad = 1'b1;
      if (k >= 4 && k <= 9 && bus.ready_o) rdy_bad = 1'b1;
      if (k == 8) ack_force = 1'b0;
      if (k == 10) check("rst_ready_after_ack_fall", bus.ready_o, 1);
    end
    check("rst_ready_held_low", rdy_bad, 0);
    check("rst_no_done", done_bad, 0);
  endtask

`ifdef CDC_REQ_CTRL_TIMEOUT_EN
  task automatic timeout_req();
    int to_cnt = 0;
    int to_at  = -1;
    int dn_at  = -1;
    ack_manual = 1'b1;
    ack_force  = 1'b0;
    accept(32'h12345678);
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (bus.timeout_o) begin
        to_cnt++;
        if (to_at < 0) to_at = k;
      end
      if (bus.done_o && dn_at < 0) dn_at = k;
      if (k == 15) check("toreq_xreq_still_high", bus.xreq_o, 1);
      if (k == 16) check("toreq_xreq_fall", bus.xreq_o, 0);
    end
    check("toreq_timeout_count", to_cnt, 1);
    check("toreq_timeout_at", to_at, 16);
    check("toreq_done_at", dn_at, 17);
    check("toreq_err_set", bus.err_o, 1);
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    check("toreq_err_cleared", bus.err_o, 0);
  endtask

  task automatic timeout_rel();
    int to_pos[$];
    int dn_at  = -1;
    bit rdy_bad = 1'b0;
    ack_manual = 1'b1;
    ack_force  = 1'b0;
    accept(32'h0BADF00D);
    ack_force = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus.timeout_o) to_pos.push_back(k);
      if (bus.done_o && dn_at < 0) begin
        dn_at = k;
        check("torel_ready_at_done", bus.ready_o, 1);
      end
      if (k < 55 && bus.ready_o) rdy_bad = 1'b1;
      case (k)
        20: bus.clr_err_i = 1'b1;
        21: begin
          check("torel_err_clear", bus.err_o, 0);
          bus.clr_err_i = 1'b0;
        end
        34: bus.clr_err_i = 1'b1;
        35: begin
          check("torel_timeout_beats_clear", bus.err_o, 1);
          bus.clr_err_i = 1'b0;
        end
        52: ack_force = 1'b0;
        default: ;
      endcase
    end
    check("torel_timeout_count", to_pos.size(), 3);
    for (int i = 0; i < to_pos.size() && i < 3; i++) check("torel_timeout_at", to_pos[i], 64'(19 + 16 * i));
    check("torel_ready_low", rdy_bad, 0);
    check("torel_done_at", dn_at, 55);
  endtask
`else
  task automatic no_timeout();
    bit to_seen  = 1'b0;
    bit err_seen = 1'b0;
    bit req_drop = 1'b0;
    ack_manual = 1'b1;
    ack_force  = 1'b0;
    accept(32'h55AA55AA);
    for (int k = 1; k <= 5000; k++) begin
      tick();
      if (bus.timeout_o) to_seen = 1'b1;
      if (bus.err_o) err_seen = 1'b1;
      if (!bus.xreq_o) req_drop = 1'b1;
    end
    check("noto_timeout_low", to_seen, 0);
    check("noto_err_low", err_seen, 0);
    check("noto_xreq_held", req_drop, 0);
  endtask
`endif

  initial begin
    vec_t vecs[4];
    vecs[0] = '{data: 32'hDEADBEEF, dly: 3, lat: 12};
    vecs[1] = '{data: 32'h00000000, dly: 0, lat: 6};
    vecs[2] = '{data: 32'hFFFFFFFF, dly: 1, lat: 8};
    vecs[3] = '{data: 32'hA5A55A5A, dly: 5, lat: 16};

    bus.valid_i   = 1'b0;
    bus.data_i    = '0;
    bus.clr_err_i = 1'b0;
    tick();
    tick();
    check("reset_ready", bus.ready_o, 1);
    check("reset_xreq", bus.xreq_o, 0);
    check("reset_xdata", bus.xdata_o, 0);
    check("reset_done", bus.done_o, 0);
    check("reset_timeout", bus.timeout_o, 0);
    check("reset_err", bus.err_o, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) do_xfer(vecs[i].data, vecs[i].dly, vecs[i].lat);

    back_to_back();
    do_reset();
    reset_mid_req();
    do_reset();
`ifdef CDC_REQ_CTRL_TIMEOUT_EN
    timeout_req();
    do_reset();
    timeout_rel();
`else
    no_timeout();
`endif
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
